// File: rtl/jericalla_pkg.sv
// Shared types and instruction-word field positions for the Jericalla sequencer.
package jericalla_pkg;

  localparam int INSTR_W     = 17;
  localparam int RAM_DIR_MSB = 16;
  localparam int RAM_DIR_LSB = 13;
  localparam int ALU_OP_MSB  = 12;
  localparam int ALU_OP_LSB  = 9;
  localparam int ROM_DIR1_MSB = 8;
  localparam int ROM_DIR1_LSB = 5;
  localparam int ROM_DIR2_MSB = 4;
  localparam int ROM_DIR2_LSB = 1;
  localparam int RAM_EN      = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETTLE,
    COMMIT,
    FINISH
  } state_t;

  // Same word with the RAM write enable cleared, used while the datapath settles.
  function automatic logic [INSTR_W-1:0] mask_we(input logic [INSTR_W-1:0] w);
    return {w[INSTR_W-1:RAM_EN+1], 1'b0};
  endfunction

endpackage

// File: rtl/jericalla_prog_mem.sv
// Program buffer: synchronous write, combinational read (the sequencer registers the read).
module jericalla_prog_mem
  import jericalla_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(PROG_DEPTH)-1:0] waddr,
  input  logic [INSTR_W-1:0]            wdata,
  input  logic [$clog2(PROG_DEPTH)-1:0] raddr,
  output logic [INSTR_W-1:0]            rdata
);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jericalla_secuenciador.sv
// Program sequencer: issues buffered instruction words to the Jericalla datapath,
// holding each one with RAM write masked for SETTLE_CYCLES before a one-cycle commit.
module jericalla_secuenciador
  import jericalla_pkg::*;
#(
  parameter int PROG_DEPTH    = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ProgWe,
  input  logic [$clog2(PROG_DEPTH)-1:0] ProgAddr,
  input  logic [INSTR_W-1:0]            ProgData,
  input  logic [$clog2(PROG_DEPTH):0]   ProgLen,
  input  logic                          StopOnZ,
  input  logic                          Start,
  input  logic                          Zflag,
  output logic [INSTR_W-1:0]            Instruccion,
  output logic [$clog2(PROG_DEPTH)-1:0] PC,
  output logic                          Busy,
  output logic                          Done,
  output logic                          ZeroHalt
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(PROG_DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  state_t             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW:0]        len_q, len_d;
  logic               soz_q, soz_d;
  logic               zreg_q, zreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [INSTR_W-1:0] ins_q, ins_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               zh_q, zh_d;
  logic [INSTR_W-1:0] word_p0;
  logic [INSTR_W-1:0] word_p1, word_d;

  // Host writes only land while idle so a running program cannot be altered.
  jericalla_prog_mem #(.PROG_DEPTH(PROG_DEPTH)) u_mem (
    .clk   (clk),
    .we    (ProgWe && (state_q == IDLE)),
    .waddr (ProgAddr),
    .wdata (ProgData),
    .raddr (pc_q),
    .rdata (word_p0)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    soz_d   = soz_q;
    zreg_d  = zreg_q;
    cnt_d   = cnt_q;
    ins_d   = ins_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    zh_d    = zh_q;
    word_d  = word_p1;
    case (state_q)
      IDLE: begin
        ins_d = '0;
        if (Start) begin
          zh_d = 1'b0;
          if (ProgLen != '0) begin
            state_d = FETCH;
            len_d   = clamp_len(ProgLen);
            soz_d   = StopOnZ;
            pc_d    = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      FETCH: begin
        word_d  = word_p0;
        ins_d   = mask_we(word_p0);
        cnt_d   = CNT_INIT;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          zreg_d  = Zflag;
          ins_d   = word_p1;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COMMIT: begin
        ins_d = '0;
        if ((soz_q && zreg_q) || ({1'b0, pc_q} == len_q - 1'b1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          zh_d    = soz_q && zreg_q;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = FETCH;
        end
      end
      FINISH: begin
        ins_d   = '0;
        state_d = IDLE;
      end
      default: begin
        ins_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      soz_q   <= 1'b0;
      zreg_q  <= 1'b0;
      cnt_q   <= '0;
      ins_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zh_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      soz_q   <= soz_d;
      zreg_q  <= zreg_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zh_q    <= zh_d;
    end
  end

  // Fetch stage: fetched word held for the settle/commit phases
  always_ff @(posedge clk) begin
    word_p1 <= word_d;
  end

  assign Instruccion = ins_q;
  assign PC          = pc_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign ZeroHalt    = zh_q;

endmodule

// File: tb/tb_jericalla_secuenciador.sv
// Scoreboard bench for jericalla_secuenciador: per-cycle expected outputs are queued at Start.
module tb_jericalla_secuenciador;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ProgWe;
  logic [3:0]  ProgAddr;
  logic [16:0] ProgData;
  logic [4:0]  ProgLen;
  logic        StopOnZ;
  logic        Start;
  logic        Zflag;
  logic [16:0] Instruccion;
  logic [3:0]  PC;
  logic        Busy;
  logic        Done;
  logic        ZeroHalt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [16:0] ins;
    logic [3:0]  pc;
    logic        pcv;
    logic        busy;
    logic        done;
    logic        zh;
  } exp_t;

  exp_t        sbq[$];
  logic [16:0] prog_m [16];

  always #5 clk = ~clk;

  jericalla_secuenciador #(.PROG_DEPTH(16), .SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ProgWe      (ProgWe),
    .ProgAddr    (ProgAddr),
    .ProgData    (ProgData),
    .ProgLen     (ProgLen),
    .StopOnZ     (StopOnZ),
    .Start       (Start),
    .Zflag       (Zflag),
    .Instruccion (Instruccion),
    .PC          (PC),
    .Busy        (Busy),
    .Done        (Done),
    .ZeroHalt    (ZeroHalt)
  );

  task automatic push(input logic [16:0] ins, input int pc, input logic pcv,
                      input logic busy, input logic done, input logic zh);
    exp_t e;
    e.ins = ins; e.pc = pc[3:0]; e.pcv = pcv; e.busy = busy; e.done = done; e.zh = zh;
    sbq.push_back(e);
  endtask

  task automatic write_word(input int a, input logic [16:0] d);
    ProgWe = 1'b1; ProgAddr = a[3:0]; ProgData = d;
    @(posedge clk); #1;
    ProgWe = 1'b0;
    prog_m[a] = d;
  endtask

  // wcyc: 0 = write buf[0] together with Start, >0 = write attempt in that run cycle, <0 = none
  task automatic run(input string name, input int len, input bit soz, input int zword,
                     input int wcyc, input logic [16:0] wdata);
    int n, k, fin_cyc, writes_exp, writes_obs;
    logic zh;
    logic [16:0] w;
    exp_t e;
    n = (len > 16) ? 16 : len;
    if (wcyc == 0) begin
      ProgWe = 1'b1; ProgAddr = 4'd0; ProgData = wdata; prog_m[0] = wdata;
    end
    sbq.delete();
    writes_exp = 0; writes_obs = 0; zh = 1'b0;
    if (n == 0) begin
      push(17'h0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      push(17'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = prog_m[i];
        push(17'h0, i, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 2; s++) push({w[16:1], 1'b0}, i, 1'b1, 1'b1, 1'b0, 1'b0);
        push(w, i, 1'b1, 1'b1, 1'b0, 1'b0);
        writes_exp += int'(w[0]);
        if ((soz && i == zword) || i == n - 1) begin
          zh = soz && (i == zword);
          push(17'h0, i, 1'b1, 1'b0, 1'b1, zh);
          push(17'h0, i, 1'b1, 1'b0, 1'b0, zh);
          break;
        end
      end
    end
    fin_cyc = sbq.size() - 1;
    ProgLen = len[4:0]; StopOnZ = soz; Start = 1'b1; Zflag = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0; ProgWe = 1'b0;
    k = 1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (Instruccion !== e.ins) begin
        errors++;
        $display("FAIL %s ins cyc%0d: got %h want %h", name, k, Instruccion, e.ins);
      end
      checks++;
      if (Busy !== e.busy) begin
        errors++;
        $display("FAIL %s busy cyc%0d: got %b want %b", name, k, Busy, e.busy);
      end
      checks++;
      if (Done !== e.done) begin
        errors++;
        $display("FAIL %s done cyc%0d: got %b want %b", name, k, Done, e.done);
      end
      checks++;
      if (ZeroHalt !== e.zh) begin
        errors++;
        $display("FAIL %s zerohalt cyc%0d: got %b want %b", name, k, ZeroHalt, e.zh);
      end
      if (e.pcv) begin
        checks++;
        if (PC !== e.pc) begin
          errors++;
          $display("FAIL %s pc cyc%0d: got %0d want %0d", name, k, PC, e.pc);
        end
      end
      if (Instruccion[0] === 1'b1) writes_obs++;
      // stimulus for the next cycle
      Zflag    = (n > 0) && ((k / 4) == zword);
      Start    = (n > 0) && ((k + 1 == 2) || (k + 1 == fin_cyc));
      ProgWe   = (wcyc > 0) && (k + 1 == wcyc);
      ProgAddr = 4'd0;
      ProgData = wdata;
      @(posedge clk); #1;
      k++;
    end
    Start = 1'b0; ProgWe = 1'b0; Zflag = 1'b0;
    checks++;
    if (writes_obs != writes_exp) begin
      errors++;
      $display("FAIL %s ram_writes: got %0d want %0d", name, writes_obs, writes_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Start = 1'b1; ProgLen = 5'd1; StopOnZ = 1'b0; Zflag = 1'b0;
    ProgWe = 1'b0; ProgAddr = 4'd0; ProgData = 17'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Instruccion !== 17'h0) begin errors++; $display("FAIL reset ins: got %h want 0", Instruccion); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", Done); end
    checks++;
    if (PC !== 4'd0) begin errors++; $display("FAIL reset pc: got %0d want 0", PC); end
    checks++;
    if (ZeroHalt !== 1'b0) begin errors++; $display("FAIL reset zerohalt: got %b want 0", ZeroHalt); end
    rst_n = 1'b1; Start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    write_word(0, 17'h0448D);
    run("single", 1, 1'b0, -1, -1, 17'h0);
  endtask

  task automatic test_three();
    write_word(1, 17'h0448D);
    write_word(2, 17'h04000);
    run("three", 3, 1'b0, -1, -1, 17'h0);
  endtask

  task automatic test_stop_on_z();
    run("stopz", 3, 1'b1, 1, -1, 17'h0);
  endtask

  task automatic test_len0_and_busy_write();
    run("len0", 0, 1'b0, -1, -1, 17'h0);
    run("busy_write", 1, 1'b0, -1, 2, 17'h1FFFF);
    run("after_busy_write", 1, 1'b0, -1, -1, 17'h0);
  endtask

  task automatic test_back_to_back();
    run("write_with_start", 1, 1'b0, -1, 0, 17'h0A5A1);
    run("b2b_three", 3, 1'b0, -1, -1, 17'h0);
  endtask

  task automatic test_midrun_reset();
    int wr;
    ProgLen = 5'd3; StopOnZ = 1'b0; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (PC !== 4'd1) begin errors++; $display("FAIL midrst pc_before: got %0d want 1", PC); end
    checks++;
    if (Instruccion !== {prog_m[1][16:1], 1'b0}) begin
      errors++; $display("FAIL midrst ins_before: got %h want %h", Instruccion, {prog_m[1][16:1], 1'b0});
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({Instruccion, PC, Busy, Done, ZeroHalt} !== 24'h0) begin
      errors++;
      $display("FAIL midrst outputs: got ins=%h pc=%0d busy=%b done=%b zh=%b want all 0",
               Instruccion, PC, Busy, Done, ZeroHalt);
    end
    wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (Instruccion[0] === 1'b1 || Busy === 1'b1) wr++;
    end
    checks++;
    if (wr != 0) begin errors++; $display("FAIL midrst abandoned: got %0d active cycles want 0", wr); end
    run("rerun_after_reset", 3, 1'b0, -1, -1, 17'h0);
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 16; i++) write_word(i, 17'($urandom));
    run("clamp", 17, 1'b0, -1, -1, 17'h0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_stop_on_z();
    test_len0_and_busy_write();
    test_back_to_back();
    test_midrun_reset();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
